// File: rtl/framebuf_reader_pkg.sv
// Shared frame-buffer definitions: FSM state encodings and the default 640x480
// frame geometry also used by display_interface and vtc.
package framebuf_reader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int FB_H_ACTIVE   = 640;
   localparam int FB_V_ACTIVE   = 480;
   localparam int FB_DATA_WIDTH = 12;
   localparam int FB_ADDR_WIDTH = 20;

   function automatic int frame_pixels(input int h_active, input int v_active);
      return h_active * v_active;
   endfunction

endpackage

// File: rtl/framebuf_reader_rd_valid_pipe.sv
// Valid shift register tracking outstanding BRAM reads; DEPTH cycles from in_vld
// to tail_vld, synchronous flush drops everything in flight. No backpressure.
module rd_valid_pipe #(
   parameter int DEPTH = 1
) (
   input  logic i_p_clk,
   input  logic i_rstn,
   input  logic flush,
   input  logic in_vld,
   output logic tail_vld,
   output logic empty
);

   logic [DEPTH-1:0] pipe;

   always_ff @(posedge i_p_clk) begin
      if (!i_rstn || flush) begin
         pipe <= '0;
      end else begin
         pipe[0] <= in_vld;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tail_vld = pipe[DEPTH-1];
   assign empty    = (pipe == '0);

endmodule

// File: rtl/framebuf_reader.sv
// Streams one frame per request from the BRAM frame buffer into the display FIFO;
// o_ren -> o_wr is RD_LATENCY+1 cycles, reads pause on almost-full, in-flight reads always land.
module framebuf_reader
   import framebuf_reader_pkg::*;
#(
   parameter int H_ACTIVE   = FB_H_ACTIVE,
   parameter int V_ACTIVE   = FB_V_ACTIVE,
   parameter int DATA_WIDTH = FB_DATA_WIDTH,
   parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_p_clk,
   input  logic                  i_rstn,
   input  logic                  i_req,
   input  logic                  i_bank,
   output logic                  o_ren,
   output logic [ADDR_WIDTH-1:0] o_raddr,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  o_wr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   input  logic                  i_wfull,
   input  logic                  i_walmostfull,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_err_restart,
   output logic                  o_err_ovf
);

   localparam logic [ADDR_WIDTH-1:0] FRAME = ADDR_WIDTH'(frame_pixels(H_ACTIVE, V_ACTIVE));
   localparam logic [ADDR_WIDTH-1:0] LAST  = FRAME - 1'b1;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] issued;
   logic [ADDR_WIDTH-1:0] base;
   logic                  pipe_tail_vld;
   logic                  pipe_empty;
   logic                  restart;
   logic                  issue;
   logic                  drain_done;

   // A request while a frame is in flight aborts it; this also beats drain completion.
   assign restart    = i_req && (state != ST_IDLE);
   assign issue      = (state == ST_READ) && !i_walmostfull && (issued != FRAME);
   assign drain_done = (state == ST_DRAIN) && !o_ren && pipe_empty;
   assign o_err_ovf  = o_wr & i_wfull;

   rd_valid_pipe #(
      .DEPTH    (RD_LATENCY)
   ) u_rd_valid_pipe (
      .i_p_clk  (i_p_clk),
      .i_rstn   (i_rstn),
      .flush    (restart),
      .in_vld   (o_ren),
      .tail_vld (pipe_tail_vld),
      .empty    (pipe_empty)
   );

   always_ff @(posedge i_p_clk) begin
      if (!i_rstn) begin
         state         <= ST_IDLE;
         issued        <= '0;
         base          <= '0;
         o_ren         <= 1'b0;
         o_raddr       <= '0;
         o_busy        <= 1'b0;
         o_frame_done  <= 1'b0;
         o_err_restart <= 1'b0;
      end else begin
         o_frame_done  <= 1'b0;
         o_err_restart <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_ren <= 1'b0;
               if (i_req) begin
                  state  <= ST_READ;
                  issued <= '0;
                  base   <= i_bank ? FRAME : '0;
                  o_busy <= 1'b1;
               end
            end
            ST_READ, ST_DRAIN: begin
               if (restart) begin
                  o_err_restart <= 1'b1;
                  o_ren         <= 1'b0;
                  issued        <= '0;
                  base          <= i_bank ? FRAME : '0;
                  state         <= ST_READ;
               end else if (state == ST_READ) begin
                  if (issue) begin
                     o_ren   <= 1'b1;
                     o_raddr <= base + issued;
                     issued  <= issued + 1'b1;
                     if (issued == LAST) begin
                        state <= ST_DRAIN;
                     end
                  end else begin
                     o_ren <= 1'b0;
                  end
               end else begin
                  o_ren <= 1'b0;
                  if (drain_done) begin
                     o_frame_done <= 1'b1;
                     o_busy       <= 1'b0;
                     state        <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               o_ren <= 1'b0;
            end
         endcase
      end
   end

   // Write side: o_wdata holds between writes; an abort kills whatever lands this cycle.
   always_ff @(posedge i_p_clk) begin
      if (!i_rstn) begin
         o_wr    <= 1'b0;
         o_wdata <= '0;
      end else if (pipe_tail_vld && !restart) begin
         o_wr    <= 1'b1;
         o_wdata <= i_rdata;
      end else begin
         o_wr    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_framebuf_reader.sv
// Bench for framebuf_reader with a 4x2 frame and a 1-cycle BRAM model (data = addr[11:0]).
module tb_framebuf_reader;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int DW = 12;
   localparam int AW = 20;
   localparam int FR = H * V;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req;
   logic          bank;
   logic          ren;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic          wr;
   logic [DW-1:0] wdata;
   logic          wfull;
   logic          walmostfull;
   logic          busy;
   logic          frame_done;
   logic          err_restart;
   logic          err_ovf;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   int rd_cnt, wr_cnt, done_cnt, rst_cnt, ovf_cnt;
   int first_ren_cyc, last_ren_cyc, first_wr_cyc, last_wr_cyc, done_cyc;

   logic [AW-1:0] addr_q[$];
   logic [DW-1:0] data_q[$];

   always #5 clk = ~clk;

   framebuf_reader #(
      .H_ACTIVE      (H),
      .V_ACTIVE      (V),
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .RD_LATENCY    (1)
   ) dut (
      .i_p_clk       (clk),
      .i_rstn        (rstn),
      .i_req         (req),
      .i_bank        (bank),
      .o_ren         (ren),
      .o_raddr       (raddr),
      .i_rdata       (rdata),
      .o_wr          (wr),
      .o_wdata       (wdata),
      .i_wfull       (wfull),
      .i_walmostfull (walmostfull),
      .o_busy        (busy),
      .o_frame_done  (frame_done),
      .o_err_restart (err_restart),
      .o_err_ovf     (err_ovf)
   );

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (ren) rdata <= raddr[DW-1:0];
   end

   // Scoreboard: every read address and every written pixel is checked against the queues.
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (ren) begin
         vectors++;
         if (addr_q.size() == 0) begin
            miscompares++;
            $display("FAIL raddr: unexpected read of %0d, none expected", raddr);
         end else begin
            ea = addr_q.pop_front();
            if (raddr !== ea) begin
               miscompares++;
               $display("FAIL raddr: got %0d want %0d", raddr, ea);
            end
         end
         if (rd_cnt == 0) first_ren_cyc = cyc;
         last_ren_cyc = cyc;
         rd_cnt++;
      end
      if (wr) begin
         vectors++;
         if (data_q.size() == 0) begin
            miscompares++;
            $display("FAIL wdata: unexpected write of 0x%03h, none expected", wdata);
         end else begin
            ed = data_q.pop_front();
            if (wdata !== ed) begin
               miscompares++;
               $display("FAIL wdata: got 0x%03h want 0x%03h", wdata, ed);
            end
         end
         if (wr_cnt == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_cnt++;
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err_restart) rst_cnt++;
      if (err_ovf) ovf_cnt++;
   end

   task automatic clear_sb();
      addr_q.delete();
      data_q.delete();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; rst_cnt = 0; ovf_cnt = 0;
      first_ren_cyc = 0; last_ren_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
   endtask

   // Called just after a rising edge; holds i_req for exactly one cycle.
   task automatic pulse_req(input logic b);
      logic [AW-1:0] base;
      req  = 1'b1;
      bank = b;
      @(negedge clk);
      #1;
      clear_sb();
      base = b ? AW'(FR) : '0;
      for (int i = 0; i < FR; i++) begin
         logic [AW-1:0] a;
         a = base + AW'(i);
         addr_q.push_back(a);
         data_q.push_back(a[DW-1:0]);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; req = 1'b0; bank = 1'b0; wfull = 1'b0; walmostfull = 1'b0;
      clear_sb();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({ren, raddr, wr, wdata, busy, frame_done, err_restart, err_ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: ren=%b raddr=%0d wr=%b wdata=%0d busy=%b done=%b rst=%b ovf=%b, all must be 0",
                  ren, raddr, wr, wdata, busy, frame_done, err_restart, err_ovf);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_bank0_frame();
      bit ok;
      pulse_req(1'b0);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_start: got %b want 1", busy);
      end
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL bank0_done_timeout: got no frame_done want one");
      end
      vectors++;
      if (rd_cnt != FR || wr_cnt != FR || done_cnt != 1) begin
         miscompares++;
         $display("FAIL bank0_counts: got rd=%0d wr=%0d done=%0d want %0d %0d 1", rd_cnt, wr_cnt, done_cnt, FR, FR);
      end
      vectors++;
      if (first_wr_cyc - first_ren_cyc != 2) begin
         miscompares++;
         $display("FAIL read_to_write_latency: got %0d want 2", first_wr_cyc - first_ren_cyc);
      end
      vectors++;
      if (done_cyc - last_wr_cyc != 1) begin
         miscompares++;
         $display("FAIL done_after_last_write: got %0d want 1", done_cyc - last_wr_cyc);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_end: got %b want 0", busy);
      end
   endtask

   task automatic test_bank1_frame();
      bit ok;
      pulse_req(1'b1);
      wait_done(ok);
      vectors++;
      if (!ok || wr_cnt != FR || done_cnt != 1 || data_q.size() != 0) begin
         miscompares++;
         $display("FAIL bank1_frame: got done=%0d wr=%0d left=%0d want 1 %0d 0", done_cnt, wr_cnt, data_q.size(), FR);
      end
   endtask

   task automatic test_almost_full();
      bit ok;
      pulse_req(1'b0);
      for (int k = 0; k < 40 && rd_cnt < 3; k++) begin
         @(posedge clk);
         #1;
      end
      walmostfull = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      walmostfull = 1'b0;
      wait_done(ok);
      vectors++;
      if (!ok || wr_cnt != FR || done_cnt != 1) begin
         miscompares++;
         $display("FAIL almost_full_frame: got done=%0d wr=%0d want 1 %0d", done_cnt, wr_cnt, FR);
      end
      vectors++;
      if (last_ren_cyc - first_ren_cyc != FR - 1 + 3) begin
         miscompares++;
         $display("FAIL almost_full_gap: got read span %0d want %0d", last_ren_cyc - first_ren_cyc, FR - 1 + 3);
      end
   endtask

   task automatic test_restart();
      bit ok;
      pulse_req(1'b0);
      for (int k = 0; k < 40 && rd_cnt < 5; k++) begin
         @(posedge clk);
         #1;
      end
      pulse_req(1'b0);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_busy: got %b want 1", busy);
      end
      wait_done(ok);
      vectors++;
      if (!ok || rst_cnt != 1 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL restart_pulses: got restart=%0d done=%0d want 1 1", rst_cnt, done_cnt);
      end
      vectors++;
      if (rd_cnt != FR || wr_cnt != FR) begin
         miscompares++;
         $display("FAIL restart_frame: got rd=%0d wr=%0d want %0d %0d", rd_cnt, wr_cnt, FR, FR);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      pulse_req(1'b0);
      for (int k = 0; k < 40 && wr_cnt < 2; k++) begin
         @(posedge clk);
         #1;
      end
      wfull = 1'b1;
      @(posedge clk);
      #1;
      wfull = 1'b0;
      wait_done(ok);
      vectors++;
      if (ovf_cnt != 1) begin
         miscompares++;
         $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt);
      end
      vectors++;
      if (!ok || wr_cnt != FR || done_cnt != 1) begin
         miscompares++;
         $display("FAIL ovf_frame: got done=%0d wr=%0d want 1 %0d", done_cnt, wr_cnt, FR);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      pulse_req(1'b0);
      for (int k = 0; k < 40 && rd_cnt < 3; k++) begin
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ren, raddr, wr, wdata, busy, frame_done, err_restart, err_ovf} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: ren=%b raddr=%0d wr=%b wdata=%0d busy=%b done=%b rst=%b ovf=%b, all must be 0",
                  ren, raddr, wr, wdata, busy, frame_done, err_restart, err_ovf);
      end
      #1;
      clear_sb();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      vectors++;
      if (rd_cnt != 0 || wr_cnt != 0 || done_cnt != 0 || rst_cnt != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_quiet: got rd=%0d wr=%0d done=%0d rst=%0d busy=%b want all 0",
                  rd_cnt, wr_cnt, done_cnt, rst_cnt, busy);
      end
      pulse_req(1'b0);
      wait_done(ok);
      vectors++;
      if (!ok || wr_cnt != FR || done_cnt != 1 || rst_cnt != 0) begin
         miscompares++;
         $display("FAIL post_reset_frame: got done=%0d wr=%0d restart=%0d want 1 %0d 0", done_cnt, wr_cnt, rst_cnt, FR);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      pulse_req(1'b1);
      wait_done(ok);
      vectors++;
      if (!ok || wr_cnt != FR || addr_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_first: got wr=%0d left=%0d want %0d 0", wr_cnt, addr_q.size(), FR);
      end
      pulse_req(1'b0);
      wait_done(ok);
      vectors++;
      if (!ok || wr_cnt != FR || done_cnt != 1 || rst_cnt != 0) begin
         miscompares++;
         $display("FAIL b2b_second: got done=%0d wr=%0d restart=%0d want 1 %0d 0", done_cnt, wr_cnt, rst_cnt, FR);
      end
   endtask

   initial begin
      test_reset();
      test_bank0_frame();
      test_bank1_frame();
      test_almost_full();
      test_restart();
      test_overflow();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
